// File: rtl/inst_fetch_resp_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_resp_pkg
// Shared types and constants for the instruction fetch responder.
//   - bus / instruction widths
//   - active levels of the reset, jump and hold controls
//   - FSM state encoding (IDLE/REQ/RESP/DROP, 2-bit)
//   - default NOP instruction returned for an abandoned fetch
// Optional feature macro used by the design: FETCH_TIMEOUT_EN.
// -----------------------------------------------------------------------------
package inst_fetch_resp_pkg;

  localparam int INST_ADDR_WIDTH = 32;
  localparam int INST_WIDTH      = 32;

  // Active levels of the pipeline control inputs.
  localparam logic       RST_ACTIVE  = 1'b1;
  localparam logic       JUMP_ACTIVE = 1'b1;
  localparam logic [1:0] HOLD_NONE   = 2'b00;
  localparam logic [1:0] HOLD_STALL  = 2'b01;

  // addi x0, x0, 0
  localparam logic [INST_WIDTH-1:0] NOP_INST_DEFAULT = 32'h0000_0013;
  localparam int                    TIMEOUT_DEFAULT  = 16;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_RESP = 2'd2,
    FETCH_DROP = 2'd3
  } fetch_state_e;

  // A bus read is in flight in these states; mem_req_o is asserted.
  function automatic logic bus_busy(input fetch_state_e s);
    return (s == FETCH_REQ) || (s == FETCH_DROP);
  endfunction

endpackage

// File: rtl/inst_fetch_resp_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_resp_if
// Instruction memory read bus between the fetch responder and memory.
// Signal names are from the fetch responder's point of view.
//   mem_req_o    read request, held until mem_ack_i
//   mem_addr_o   read address, stable while mem_req_o is high
//   mem_ack_i    read data valid, single-cycle pulse
//   mem_rdata_i  read data, valid with mem_ack_i
// Modports: master (fetch responder), slave (memory).
// Handshake: a request, once raised, is never withdrawn before its ack
// (except by reset or the optional fetch timeout); exactly one ack pulse
// completes it, and at most one request is outstanding.
// -----------------------------------------------------------------------------
interface inst_fetch_resp_if;
  import inst_fetch_resp_pkg::*;

  logic                        mem_req_o;
  logic [INST_ADDR_WIDTH-1:0]  mem_addr_o;
  logic                        mem_ack_i;
  logic [INST_WIDTH-1:0]       mem_rdata_i;

  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_ack_i,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_ack_i,
    output mem_rdata_i
  );

endinterface

// File: rtl/fetch_wait_cnt.sv
// -----------------------------------------------------------------------------
// fetch_wait_cnt
// Counts bus-wait cycles of an outstanding fetch for the timeout feature
// (only instantiated when FETCH_TIMEOUT_EN is defined).
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   clear_i      restart the count (entry into a bus-wait state)
//   count_i      one more cycle waited without an ack
//   expired_o    count has reached TIMEOUT-1
// The count saturates at TIMEOUT-1 so expired_o stays up until cleared.
// -----------------------------------------------------------------------------
module fetch_wait_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expired_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/inst_fetch_resp.sv
// -----------------------------------------------------------------------------
// inst_fetch_resp
// Fetch responder between the pc stage and the instruction memory bus.
// Accepts one fetch address from pc, performs one req/ack read on the bus
// and presents the instruction plus its address to the pc/ID boundary.
// At most one fetch is outstanding; jump flushes, hold stalls the result.
//
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   pc_i           fetch address
//   pc_valid_i     pc_i valid; accepted when pc_valid_i && fetch_rdy_o
//   fetch_rdy_o    responder can take a new address this cycle
//   jump_i         flush the current fetch/result
//   hold_i         HOLD_STALL keeps the presented result
//   mem            instruction bus (master modport)
//   inst_o         fetched instruction (NOP_INST after reset/timeout)
//   inst_addr_o    address of inst_o
//   inst_valid_o   inst_o/inst_addr_o valid
//   fetch_err_o    inst_o is NOP_INST from an abandoned fetch
//   state_o        current FSM state (debug)
//
// Configuration macro: FETCH_TIMEOUT_EN -- abandon a bus read after TIMEOUT
// wait cycles. Without it REQ/DROP wait indefinitely and fetch_err_o is 0.
//
// Handshake: pc side is valid/ready, transfer when both are high in the same
// cycle; bus side holds mem_req_o and mem_addr_o until a one-cycle mem_ack_i.
// -----------------------------------------------------------------------------
module inst_fetch_resp
  import inst_fetch_resp_pkg::*;
#(
  parameter int                    TIMEOUT  = TIMEOUT_DEFAULT,
  parameter logic [INST_WIDTH-1:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [INST_ADDR_WIDTH-1:0]  pc_i,
  input  logic                        pc_valid_i,
  output logic                        fetch_rdy_o,
  input  logic                        jump_i,
  input  logic [1:0]                  hold_i,
  inst_fetch_resp_if.master           mem,
  output logic [INST_WIDTH-1:0]       inst_o,
  output logic [INST_ADDR_WIDTH-1:0]  inst_addr_o,
  output logic                        inst_valid_o,
  output logic                        fetch_err_o,
  output fetch_state_e                state_o
);

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("inst_fetch_resp: TIMEOUT must be at least 2");
  end

  fetch_state_e                state_q, state_d;
  logic [INST_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [INST_WIDTH-1:0]       inst_q, inst_d;
  logic [INST_ADDR_WIDTH-1:0]  inst_addr_q, inst_addr_d;
  logic                        err_q, err_d;
  logic                        rdy;
  logic                        timeout;

  logic jump;
  logic hold;
  logic ack;

  assign jump = (jump_i == JUMP_ACTIVE);
  assign hold = (hold_i == HOLD_STALL);
  // Acks outside REQ/DROP are protocol errors; masking here ignores them.
  assign ack  = mem.mem_ack_i && bus_busy(state_q);

  // ---------------------------------------------------------------------------
  // Optional bus-wait timeout
  // ---------------------------------------------------------------------------
`ifdef FETCH_TIMEOUT_EN
  logic wait_clear;
  logic wait_count;
  logic wait_expired;

  // Restart on every entry into a bus-wait state, including REQ->DROP and
  // the back-to-back RESP->REQ path.
  assign wait_clear = bus_busy(state_d) && (state_d != state_q);
  assign wait_count = bus_busy(state_q) && !mem.mem_ack_i;
  assign timeout    = bus_busy(state_q) && wait_expired && !mem.mem_ack_i;

  fetch_wait_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_fetch_wait_cnt (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (wait_clear),
    .count_i   (wait_count),
    .expired_o (wait_expired)
  );
`else
  assign timeout = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM next state and output register updates
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    inst_d      = inst_q;
    inst_addr_d = inst_addr_q;
    err_d       = err_q;
    rdy         = 1'b0;

    unique case (state_q)
      FETCH_IDLE: begin
        rdy = 1'b1;
        if (pc_valid_i) begin
          addr_d  = pc_i;
          state_d = FETCH_REQ;
        end
      end

      FETCH_REQ: begin
        if (ack) begin
          if (jump) begin
            // Flushed in the ack cycle: the data is simply dropped.
            state_d = FETCH_IDLE;
          end else begin
            inst_d      = mem.mem_rdata_i;
            inst_addr_d = addr_q;
            err_d       = 1'b0;
            state_d     = FETCH_RESP;
          end
        end else if (jump) begin
          // The request cannot be withdrawn, so wait for its ack in DROP.
          // If the read is being abandoned anyway, there is nothing to drain.
          state_d = timeout ? FETCH_IDLE : FETCH_DROP;
        end else if (timeout) begin
          inst_d      = NOP_INST;
          inst_addr_d = addr_q;
          err_d       = 1'b1;
          state_d     = FETCH_RESP;
        end
      end

      FETCH_DROP: begin
        if (ack || timeout) begin
          state_d = FETCH_IDLE;
        end
      end

      FETCH_RESP: begin
        if (jump) begin
          // Flush wins over hold and over a same-cycle accept.
          state_d = FETCH_IDLE;
        end else if (!hold) begin
          rdy = 1'b1;
          if (pc_valid_i) begin
            addr_d  = pc_i;
            state_d = FETCH_REQ;
          end else begin
            state_d = FETCH_IDLE;
          end
        end
      end

      default: state_d = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FETCH_IDLE;
      addr_q      <= '0;
      inst_q      <= NOP_INST;
      inst_addr_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      inst_q      <= inst_d;
      inst_addr_q <= inst_addr_d;
      err_q       <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registered state so reset clears them at once.
  // ---------------------------------------------------------------------------
  assign mem.mem_req_o  = bus_busy(state_q);
  assign mem.mem_addr_o = addr_q;

  // Not ready while reset is held, even though the state reads IDLE.
  assign fetch_rdy_o  = rdy && (rst != RST_ACTIVE);
  assign inst_o       = inst_q;
  assign inst_addr_o  = inst_addr_q;
  assign inst_valid_o = (state_q == FETCH_RESP);
  assign fetch_err_o  = err_q;
  assign state_o      = state_q;

endmodule
